// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB operand forwarding, ALU-control decode and load-use detect; 1-cycle latency.
// Backpressure: hold keeps the instruction (refreshing forwarded operands), flush or reset loads a bubble.
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [5:0]  id_funct,
  input  logic [1:0]  id_aluop,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [2:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wreg,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_illegal,
  output logic        load_use_stall
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } idex_t;

  idex_t       r;
  idex_t       load_d;
  logic [31:0] fa;
  logic [31:0] fb;
  logic        funct_bad;

  always_comb begin
    load_d          = '0;
    load_d.valid    = id_valid;
    load_d.rs_val   = id_rs_val;
    load_d.rt_val   = id_rt_val;
    load_d.imm      = id_imm;
    load_d.rs       = id_rs;
    load_d.rt       = id_rt;
    load_d.rd       = id_rd;
    load_d.funct    = id_funct;
    load_d.aluop    = id_aluop;
    load_d.alusrc   = id_alusrc;
    load_d.regdst   = id_regdst;
    load_d.regwrite = id_valid & id_regwrite;
    load_d.memread  = id_valid & id_memread;
    load_d.memwrite = id_valid & id_memwrite;
    load_d.memtoreg = id_valid & id_memtoreg;
  end

  // While held, operands are re-captured each cycle so a retiring WB source is not lost.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r <= '0;
    end else if (hold) begin
      r.rs_val <= fa;
      r.rt_val <= fb;
    end else begin
      r <= load_d;
    end
  end

  always_comb begin
    fa = r.rs_val;
    if (mem_regwrite && (mem_rd == r.rs) && (r.rs != 5'd0))
      fa = mem_result;
    else if (wb_regwrite && (wb_rd == r.rs) && (r.rs != 5'd0))
      fa = wb_data;
  end

  always_comb begin
    fb = r.rt_val;
    if (mem_regwrite && (mem_rd == r.rt) && (r.rt != 5'd0))
      fb = mem_result;
    else if (wb_regwrite && (wb_rd == r.rt) && (r.rt != 5'd0))
      fb = wb_data;
  end

  always_comb begin
    alu_ctl   = 3'b010;
    funct_bad = 1'b0;
    case (r.aluop)
      2'b00: alu_ctl = 3'b010;
      2'b01: alu_ctl = 3'b110;
      2'b11: alu_ctl = 3'b001;
      default: begin
        case (r.funct)
          6'b100000: alu_ctl = 3'b010;
          6'b100010: alu_ctl = 3'b110;
          6'b100100: alu_ctl = 3'b000;
          6'b100101: alu_ctl = 3'b001;
          6'b101010: alu_ctl = 3'b111;
          default:   funct_bad = 1'b1;
        endcase
      end
    endcase
  end

  assign alu_a         = fa;
  assign alu_b         = r.alusrc ? r.imm : fb;
  assign ex_store_data = fb;
  assign ex_wreg       = r.regdst ? r.rd : r.rt;
  assign ex_valid      = r.valid;
  assign ex_regwrite   = r.regwrite;
  assign ex_memread    = r.memread;
  assign ex_memwrite   = r.memwrite;
  assign ex_memtoreg   = r.memtoreg;
  assign ex_illegal    = r.valid & funct_bad;

  assign load_use_stall = r.valid & r.memread & (ex_wreg != 5'd0) &
                          ((ex_wreg == id_rs) | (ex_wreg == id_rt)) & id_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: instruction-level reference model plus hand-computed spot checks.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, hold, flush, id_valid;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_data;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_wreg;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;
  logic        load_use_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction currently sitting in EX, as plain fields.
  logic        model_ok = 1'b0;
  logic        m_valid, m_alusrc, m_regdst, m_rw, m_mr, m_mw, m_mtr;
  logic [31:0] m_rsv, m_rtv, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [5:0]  m_funct;
  logic [1:0]  m_aluop;

  function automatic logic [31:0] operand(input logic [4:0] spec, input logic [31:0] regval);
    if (spec == 0) return regval;
    if (mem_regwrite && mem_rd == spec) return mem_result;
    if (wb_regwrite && wb_rd == spec) return wb_data;
    return regval;
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] fn);
    // {illegal, ctl}
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    if (fn == 6'h20) return 4'b0010;
    if (fn == 6'h22) return 4'b0110;
    if (fn == 6'h24) return 4'b0000;
    if (fn == 6'h25) return 4'b0001;
    if (fn == 6'h2a) return 4'b0111;
    return 4'b1010;
  endfunction

  task automatic model_clear();
    {m_valid, m_alusrc, m_regdst, m_rw, m_mr, m_mw, m_mtr} = '0;
    {m_rsv, m_rtv, m_imm} = '0;
    {m_rs, m_rt, m_rd, m_funct, m_aluop} = '0;
  endtask

  always @(posedge clk) begin
    if (reset || flush) begin
      model_clear();
      if (reset) model_ok = 1'b1;
    end else if (hold) begin
      m_rsv = operand(m_rs, m_rsv);
      m_rtv = operand(m_rt, m_rtv);
    end else begin
      m_valid = id_valid;  m_rsv = id_rs_val; m_rtv = id_rt_val; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_funct = id_funct; m_aluop = id_aluop;
      m_alusrc = id_alusrc; m_regdst = id_regdst;
      m_rw = id_valid && id_regwrite; m_mr = id_valid && id_memread;
      m_mw = id_valid && id_memwrite; m_mtr = id_valid && id_memtoreg;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea, eb;
    logic [4:0]  ew;
    logic [3:0]  dec;
    #3;
    if (model_ok) begin
      ea  = operand(m_rs, m_rsv);
      eb  = operand(m_rt, m_rtv);
      ew  = m_regdst ? m_rd : m_rt;
      dec = decode(m_aluop, m_funct);
      chk("m_alu_ctl", 32'(alu_ctl), 32'(dec[2:0]));
      chk("m_alu_a", alu_a, ea);
      chk("m_alu_b", alu_b, m_alusrc ? m_imm : eb);
      chk("m_store", ex_store_data, eb);
      chk("m_wreg", 32'(ex_wreg), 32'(ew));
      chk("m_ctrl", {27'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
          {27'd0, m_valid, m_rw, m_mr, m_mw, m_mtr});
      chk("m_illegal", 32'(ex_illegal), 32'(m_valid & dec[3]));
      chk("m_stall", 32'(load_use_stall),
          32'(m_valid && m_mr && ew != 0 && (ew == id_rs || ew == id_rt) && id_valid));
    end
  end

  task automatic idle();
    id_valid = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_funct = 0; id_aluop = 0;
    id_alusrc = 0; id_regdst = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  task automatic no_fwd();
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                       input logic [1:0] aluop, input logic [5:0] funct,
                       input logic alusrc, input logic regdst, input logic rw, input logic mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_val = rsv; id_rt_val = rtv;
    id_imm = imm; id_aluop = aluop; id_funct = funct; id_alusrc = alusrc; id_regdst = regdst;
    id_regwrite = rw; id_memread = mr; id_memwrite = 0; id_memtoreg = mr;
  endtask

  task automatic slot();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; hold = 0; flush = 0;
    idle(); no_fwd();
    repeat (2) @(posedge clk);
    slot(); reset = 0; #2;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_alu_ctl", 32'(alu_ctl), 32'b010);
    chk("rst_regwrite", 32'(ex_regwrite), 0);
    chk("rst_stall", 32'(load_use_stall), 0);

    // R-type sub
    slot(); instr(5'd3, 5'd4, 5'd8, 32'd10, 32'd3, 32'd0, 2'b10, 6'b100010, 0, 1, 1, 0);
    slot(); idle(); #2;
    chk("sub_ctl", 32'(alu_ctl), 32'b110);
    chk("sub_a", alu_a, 32'd10);
    chk("sub_b", alu_b, 32'd3);
    chk("sub_wreg", 32'(ex_wreg), 32'd8);

    // MEM beats WB, WB when MEM idle, $0 never forwarded
    slot(); instr(5'd5, 5'd9, 5'd0, 32'h99, 32'h1, 32'd0, 2'b00, 6'd0, 0, 0, 1, 0);
    slot(); idle(); hold = 1;
    mem_regwrite = 1; mem_rd = 5'd5; mem_result = 32'h11;
    wb_regwrite = 1; wb_rd = 5'd5; wb_data = 32'h22; #2;
    chk("fwd_mem_prio", alu_a, 32'h11);
    slot(); mem_regwrite = 0; #2;
    chk("fwd_wb", alu_a, 32'h22);
    slot(); hold = 0; instr(5'd0, 5'd0, 5'd0, 32'h77, 32'h66, 32'd0, 2'b00, 6'd0, 0, 0, 1, 0);
    slot(); idle(); mem_regwrite = 1; mem_rd = 0; wb_regwrite = 1; wb_rd = 0; #2;
    chk("fwd_zero_a", alu_a, 32'h77);
    chk("fwd_zero_b", alu_b, 32'h66);

    // Hold refresh keeps a WB-forwarded value after WB retires
    slot(); no_fwd(); instr(5'd1, 5'd6, 5'd2, 32'h1, 32'h33, 32'd0, 2'b00, 6'd0, 0, 1, 1, 0);
    slot(); idle(); hold = 1; wb_regwrite = 1; wb_rd = 5'd6; wb_data = 32'h55; #2;
    chk("hold_b0", alu_b, 32'h55);
    slot(); wb_regwrite = 0; #2;
    chk("hold_b1", alu_b, 32'h55);
    chk("hold_store", ex_store_data, 32'h55);

    // Load-use, then flush with hold
    slot(); hold = 0; no_fwd(); instr(5'd1, 5'd7, 5'd0, 32'h100, 32'h0, 32'd4, 2'b00, 6'd0, 1, 0, 1, 1);
    slot(); instr(5'd7, 5'd2, 5'd3, 32'h0, 32'h0, 32'd0, 2'b10, 6'h20, 0, 1, 1, 0); #2;
    chk("lu_stall", 32'(load_use_stall), 1);
    chk("lu_wreg", 32'(ex_wreg), 32'd7);
    chk("lu_imm_b", alu_b, 32'd4);
    slot(); flush = 1; hold = 1;
    slot(); flush = 0; hold = 0; idle(); #2;
    chk("lu_flush_valid", 32'(ex_valid), 0);
    chk("lu_flush_mr", 32'(ex_memread), 0);

    // Illegal funct, then flushed
    slot(); instr(5'd2, 5'd3, 5'd4, 32'h5, 32'h6, 32'd0, 2'b10, 6'b000111, 0, 1, 1, 0);
    slot(); idle(); flush = 1; #2;
    chk("ill_ctl", 32'(alu_ctl), 32'b010);
    chk("ill_flag", 32'(ex_illegal), 1);
    slot(); flush = 0; #2;
    chk("ill_cleared", 32'(ex_illegal), 0);

    // Reset wins over hold
    slot(); instr(5'd2, 5'd3, 5'd4, 32'h5, 32'h6, 32'd0, 2'b00, 6'd0, 0, 1, 1, 0);
    slot(); idle(); hold = 1; reset = 1;
    slot(); hold = 0; reset = 0; #2;
    chk("rst_hold_valid", 32'(ex_valid), 0);

    // id_valid=0 strips controls but fields still load
    slot(); instr(5'd2, 5'd3, 5'd4, 32'h5, 32'h6, 32'd0, 2'b11, 6'd0, 0, 1, 1, 1); id_valid = 0;
    slot(); idle(); #2;
    chk("inv_regwrite", 32'(ex_regwrite), 0);
    chk("inv_memread", 32'(ex_memread), 0);
    chk("inv_or_ctl", 32'(alu_ctl), 32'b001);

    slot(); slot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
